// File: rtl/wam_pkg.sv
// Shared constants and helpers for the keypad scanner (wam_kpd) and its debouncer.
package wam_pkg;

   localparam int NUM_KEYS = 16;
   localparam int NUM_COLS = 4;
   localparam int NUM_ROWS = 4;
   localparam int KEY_LFT  = 8;
   localparam int KEY_RGT  = 9;

   // Bits needed to hold a counter ranging 0..max_val; also sizes the debounce counter from DEB_CNT.
   function automatic int cnt_width(input int max_val);
      if (max_val < 2) begin
         cnt_width = 1;
      end else begin
         cnt_width = $clog2(max_val + 1);
      end
   endfunction

   // Index of the lowest set bit; 0 when nothing is set.
   function automatic logic [3:0] lowest_idx(input logic [NUM_KEYS-1:0] v);
      lowest_idx = 4'd0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (v[i]) begin
            lowest_idx = 4'(i);
         end else begin
            lowest_idx = lowest_idx;
         end
      end
   endfunction

endpackage

// File: rtl/wam_kpd_deb.sv
// Single-key debouncer: saturating agreement counter with hysteresis state bit.
// press is combinational and only asserts in an enabled cycle that sets the state.
module wam_kpd_deb
   import wam_pkg::*;
#(
   parameter int DEB_CNT = 3
) (
   input  logic clk,
   input  logic clr,
   input  logic en,
   input  logic hit,
   output logic press,
   output logic dn
);

   localparam int DW = cnt_width(DEB_CNT);
   localparam logic [DW-1:0] D_MAX  = DW'(DEB_CNT);
   localparam logic [DW-1:0] D_ZERO = {DW{1'b0}};

   logic [DW-1:0] d_r;
   logic [DW-1:0] d_nxt_s;
   logic          s_r;
   logic          s_nxt_s;
   logic          fire_s;

   // Next counter/state: count toward the sample, flip state only at the rails.
   always_comb begin
      d_nxt_s = d_r;
      s_nxt_s = s_r;
      fire_s  = 1'b0;
      if (!en) begin
         d_nxt_s = d_r;
      end else if (hit) begin
         if (d_r != D_MAX) begin
            d_nxt_s = d_r + DW'(1);
         end else begin
            d_nxt_s = d_r;
         end
         if ((d_nxt_s == D_MAX) && !s_r) begin
            s_nxt_s = 1'b1;
            fire_s  = 1'b1;
         end else begin
            s_nxt_s = s_r;
         end
      end else begin
         if (d_r != D_ZERO) begin
            d_nxt_s = d_r - DW'(1);
         end else begin
            d_nxt_s = d_r;
         end
         if ((d_nxt_s == D_ZERO) && s_r) begin
            s_nxt_s = 1'b0;
         end else begin
            s_nxt_s = s_r;
         end
      end
   end

   // Counter and state registers.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         d_r <= D_ZERO;
         s_r <= 1'b0;
      end else begin
         d_r <= d_nxt_s;
         s_r <= s_nxt_s;
      end
   end

   assign press = fire_s;
   assign dn    = s_r;

endmodule

// File: rtl/wam_kpd.sv
// wam_kpd: 4x4 keypad column scanner, 16 debouncers and registered one-cycle press events.
// Define WAM_KPD_REPEAT_EN to auto-repeat keys 8/9 every RPT_SCANS scan rounds while held.
module wam_kpd
   import wam_pkg::*;
#(
   parameter int SCAN_DIV = 65536,
   parameter int DEB_CNT  = 3
`ifdef WAM_KPD_REPEAT_EN
   ,
   parameter int RPT_SCANS = 32
`endif
) (
   input  logic                clk,
   input  logic                clr,
   input  logic [NUM_ROWS-1:0] row,
   output logic [NUM_COLS-1:0] col,
   output logic [7:0]          tap,
   output logic                lft,
   output logic                rgt,
   output logic                key_vld,
   output logic [3:0]          key_code,
   output logic [NUM_KEYS-1:0] key_dn
);

   localparam int PW  = cnt_width(SCAN_DIV - 1);
   localparam int CIW = $clog2(NUM_COLS);

   logic [PW-1:0]       pre_r;
   logic                tick_s;
   logic [CIW-1:0]      col_idx_r;
   logic [NUM_COLS-1:0] col_r;
   logic [NUM_ROWS-1:0] sync1_r;
   logic [NUM_ROWS-1:0] sync2_r;
   logic [NUM_KEYS-1:0] en_s;
   logic [NUM_KEYS-1:0] hit_s;
   logic [NUM_KEYS-1:0] press_s;
   logic [NUM_KEYS-1:0] dn_s;
   logic [NUM_KEYS-1:0] ev_s;
   logic [7:0]          tap_r;
   logic                lft_r;
   logic                rgt_r;
   logic                key_vld_r;
   logic [3:0]          key_code_r;

   assign tick_s = (pre_r == PW'(SCAN_DIV - 1));

   // Prescaler, column stepper and column drive.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         pre_r     <= {PW{1'b0}};
         col_idx_r <= {CIW{1'b0}};
         col_r     <= 4'b1110;
      end else if (tick_s) begin
         pre_r     <= {PW{1'b0}};
         col_idx_r <= col_idx_r + CIW'(1);
         col_r     <= ~(4'b0001 << (col_idx_r + CIW'(1)));
      end else begin
         pre_r     <= pre_r + PW'(1);
         col_idx_r <= col_idx_r;
         col_r     <= col_r;
      end
   end

   // Two-flop row synchronizer; idle rows read high.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         sync1_r <= 4'b1111;
         sync2_r <= 4'b1111;
      end else begin
         sync1_r <= row;
         sync2_r <= sync1_r;
      end
   end

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      assign en_s[k]  = tick_s && (col_idx_r == CIW'(k / NUM_ROWS));
      assign hit_s[k] = ~sync2_r[k % NUM_ROWS];
      wam_kpd_deb #(.DEB_CNT(DEB_CNT)) u_deb (
         .clk   (clk),
         .clr   (clr),
         .en    (en_s[k]),
         .hit   (hit_s[k]),
         .press (press_s[k]),
         .dn    (dn_s[k])
      );
   end

`ifdef WAM_KPD_REPEAT_EN
   localparam int RW = cnt_width(RPT_SCANS - 1);
   localparam logic [RW-1:0] R_LAST = RW'(RPT_SCANS - 1);

   logic [1:0] rep_s;

   // Repeat counts advance on the key's own samples, so re-fires land RPT_SCANS rounds apart.
   for (genvar j = 0; j < 2; j++) begin : g_rpt
      localparam int KEY = KEY_LFT + j;
      logic [RW-1:0] rpt_r;

      assign rep_s[j] = en_s[KEY] && hit_s[KEY] && dn_s[KEY] && (rpt_r == R_LAST);

      // Per-key round counter, cleared by any released sample.
      always_ff @(posedge clk or negedge clr) begin
         if (!clr) begin
            rpt_r <= {RW{1'b0}};
         end else if (en_s[KEY]) begin
            if (hit_s[KEY] && dn_s[KEY]) begin
               if (rpt_r == R_LAST) begin
                  rpt_r <= {RW{1'b0}};
               end else begin
                  rpt_r <= rpt_r + RW'(1);
               end
            end else begin
               rpt_r <= {RW{1'b0}};
            end
         end else begin
            rpt_r <= rpt_r;
         end
      end
   end
`endif

   // Event vector: debounced presses plus any repeat re-fires.
   always_comb begin
      ev_s = press_s;
`ifdef WAM_KPD_REPEAT_EN
      ev_s[KEY_LFT] = press_s[KEY_LFT] | rep_s[0];
      ev_s[KEY_RGT] = press_s[KEY_RGT] | rep_s[1];
`endif
   end

   // Registered event outputs; key_code holds between events.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         tap_r      <= 8'd0;
         lft_r      <= 1'b0;
         rgt_r      <= 1'b0;
         key_vld_r  <= 1'b0;
         key_code_r <= 4'd0;
      end else begin
         tap_r     <= ev_s[7:0];
         lft_r     <= ev_s[KEY_LFT];
         rgt_r     <= ev_s[KEY_RGT];
         key_vld_r <= |ev_s;
         if (|ev_s) begin
            key_code_r <= lowest_idx(ev_s);
         end else begin
            key_code_r <= key_code_r;
         end
      end
   end

   assign col      = col_r;
   assign tap      = tap_r;
   assign lft      = lft_r;
   assign rgt      = rgt_r;
   assign key_vld  = key_vld_r;
   assign key_code = key_code_r;
   assign key_dn   = dn_s;

endmodule

// File: tb/tb_wam_kpd.sv
// Table-driven bench for wam_kpd with a keypad matrix model; SCAN_DIV=4 so one scan is 16 cycles.
module tb_wam_kpd;

   logic        clk;
   logic        clr;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [7:0]  tap;
   logic        lft;
   logic        rgt;
   logic        key_vld;
   logic [3:0]  key_code;
   logic [15:0] key_dn;
   logic [15:0] held;

   int n_chk;
   int n_bad;

   // Event monitor state, cleared at each reset.
   int         cyc;
   int         vld_cnt;
   int         tap_cyc;
   int         lft_cnt;
   int         rgt_cnt;
   int         first_cyc;
   logic [7:0] tap_or;

   wam_kpd #(
      .SCAN_DIV(4),
`ifdef WAM_KPD_REPEAT_EN
      .RPT_SCANS(2),
`endif
      .DEB_CNT(3)
   ) dut (
      .clk      (clk),
      .clr      (clr),
      .row      (row),
      .col      (col),
      .tap      (tap),
      .lft      (lft),
      .rgt      (rgt),
      .key_vld  (key_vld),
      .key_code (key_code),
      .key_dn   (key_dn)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad matrix: a held key shorts its row to the driven-low column.
   always_comb begin
      row = 4'b1111;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            if (!col[c] && held[c*4+r]) row[r] = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (clr) begin
         cyc = cyc + 1;
         if (key_vld) begin
            vld_cnt = vld_cnt + 1;
            if (first_cyc == 0) first_cyc = cyc;
         end
         if (tap != 8'd0) tap_cyc = tap_cyc + 1;
         tap_or  = tap_or | tap;
         lft_cnt = lft_cnt + int'(lft);
         rgt_cnt = rgt_cnt + int'(rgt);
      end
   end

   typedef struct {
      logic [15:0] h1;
      int          s1;
      logic [15:0] h2;
      int          s2;
      logic [15:0] h3;
      int          s3;
      int          e_vld;
      logic [7:0]  e_tap;
      int          e_tcyc;
      int          e_lft;
      int          e_rgt;
      int          e_first;
      logic [3:0]  e_code;
      logic [15:0] e_dn;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string nm, input int act, input int exp);
      n_chk = n_chk + 1;
      if (act != exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   task automatic clear_mon();
      cyc = 0; vld_cnt = 0; tap_cyc = 0; lft_cnt = 0; rgt_cnt = 0; first_cyc = 0;
      tap_or = 8'd0;
   endtask

   task automatic do_reset(input logic [15:0] h);
      @(negedge clk); #1;
      clr  = 1'b0;
      held = h;
      clear_mon();
      repeat (3) @(negedge clk);
      #1;
      clr = 1'b1;
   endtask

   task automatic run_scans(input int n);
      repeat (16 * n) @(negedge clk);
      #1;
   endtask

   initial begin
      n_chk = 0;
      n_bad = 0;
      clr   = 1'b0;
      held  = 16'h0000;
      clear_mon();

      // Reset state while clr is held low.
      repeat (3) @(negedge clk);
      #1;
      chk("rst_col", int'(col), 4'b1110);
      chk("rst_tap", int'(tap), 0);
      chk("rst_lft", int'(lft), 0);
      chk("rst_rgt", int'(rgt), 0);
      chk("rst_vld", int'(key_vld), 0);
      chk("rst_code", int'(key_code), 0);
      chk("rst_dn", int'(key_dn), 0);

      //          h1        s1 h2        s2 h3        s3 vld tap    tcyc lft rgt first code   dn
      vecs[0] = '{16'h0020, 6, 16'h0000, 0, 16'h0000, 0, 1, 8'h20, 1, 0, 0, 40, 4'd5,  16'h0020};
      vecs[1] = '{16'h0003, 4, 16'h0000, 0, 16'h0000, 0, 1, 8'h03, 1, 0, 0, 36, 4'd0,  16'h0003};
      vecs[2] = '{16'h0100, 3, 16'h0000, 3, 16'h0100, 3, 2, 8'h00, 0, 2, 0, 44, 4'd8,  16'h0100};
      vecs[3] = '{16'h0200, 4, 16'h0000, 0, 16'h0000, 0, 1, 8'h00, 0, 0, 1, 44, 4'd9,  16'h0200};
      vecs[4] = '{16'h1000, 3, 16'h0000, 0, 16'h0000, 0, 1, 8'h00, 0, 0, 0, 48, 4'd12, 16'h1000};
      vecs[5] = '{16'h0080, 2, 16'h0000, 0, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 0,  4'd0,  16'h0000};
      vecs[6] = '{16'h8008, 3, 16'h0000, 0, 16'h0000, 0, 2, 8'h08, 1, 0, 0, 36, 4'd15, 16'h8008};
      vecs[7] = '{16'h0300, 3, 16'h0000, 0, 16'h0000, 0, 1, 8'h00, 0, 1, 1, 44, 4'd8,  16'h0300};
      vecs[8] = '{16'h0020, 3, 16'h0000, 2, 16'h0000, 0, 1, 8'h20, 1, 0, 0, 40, 4'd5,  16'h0020};

      for (int v = 0; v < 9; v++) begin
         do_reset(vecs[v].h1);
         run_scans(vecs[v].s1);
         held = vecs[v].h2;
         run_scans(vecs[v].s2);
         held = vecs[v].h3;
         run_scans(vecs[v].s3);
         chk($sformatf("v%0d_vld_cnt", v), vld_cnt, vecs[v].e_vld);
         chk($sformatf("v%0d_tap_or", v), int'(tap_or), int'(vecs[v].e_tap));
         chk($sformatf("v%0d_tap_cyc", v), tap_cyc, vecs[v].e_tcyc);
         chk($sformatf("v%0d_lft_cnt", v), lft_cnt, vecs[v].e_lft);
         chk($sformatf("v%0d_rgt_cnt", v), rgt_cnt, vecs[v].e_rgt);
         chk($sformatf("v%0d_first_cyc", v), first_cyc, vecs[v].e_first);
         chk($sformatf("v%0d_code", v), int'(key_code), int'(vecs[v].e_code));
         chk($sformatf("v%0d_dn", v), int'(key_dn), int'(vecs[v].e_dn));
      end

      // Bounce: key 5 present on alternate scans only.
      do_reset(16'h0020);
      for (int i = 0; i < 8; i++) begin
         held = (i % 2 == 0) ? 16'h0020 : 16'h0000;
         run_scans(1);
      end
      chk("bounce_vld", vld_cnt, 0);
      chk("bounce_tap", tap_cyc, 0);
      chk("bounce_dn", int'(key_dn), 0);

      // Reset after two pressed samples of key 3 discards the progress.
      do_reset(16'h0008);
      run_scans(2);
      chk("mid_pre_vld", vld_cnt, 0);
      clr = 1'b0;
      @(negedge clk); #1;
      chk("mid_rst_col", int'(col), 4'b1110);
      chk("mid_rst_dn", int'(key_dn), 0);
      clear_mon();
      @(negedge clk); #1;
      clr = 1'b1;
      run_scans(2);
      chk("mid_2scan_vld", vld_cnt, 0);
      run_scans(1);
      chk("mid_vld", vld_cnt, 1);
      chk("mid_tap_or", int'(tap_or), 8'h08);
      chk("mid_tap_cyc", tap_cyc, 1);
      chk("mid_first", first_cyc, 36);

      // Key 9 held for 8 scans.
      do_reset(16'h0200);
      run_scans(8);
`ifdef WAM_KPD_REPEAT_EN
      chk("rpt_rgt", rgt_cnt, 3);
      chk("rpt_vld", vld_cnt, 3);
`else
      chk("rpt_rgt", rgt_cnt, 1);
      chk("rpt_vld", vld_cnt, 1);
`endif
      chk("rpt_lft", lft_cnt, 0);
      chk("rpt_first", first_cyc, 44);
      chk("rpt_code", int'(key_code), 9);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/wam_kpd.md
Name: wam_kpd

Overview:
- Input-side counterpart to the digit-tube scanner: drives a 4x4 keypad matrix one column at a time, samples the rows, debounces all 16 keys and emits one-cycle press events.
- Keys 0-7 feed the mole-hit path as a tap vector. Key 8 and key 9 replace the lft/rgt difficulty buttons.
- Sits beside the tap/hit logic in the game top and runs on the main clock.

Parameters:
- SCAN_DIV, 65536, clock cycles per column step (prescaler period).
- DEB_CNT, 3, consecutive agreeing samples needed to change a key's debounced state.
- RPT_SCANS, 32, full scan rounds per auto-repeat interval (used only with the optional feature).

Ports:
- clk  in  1  main clock
- clr  in  1  asynchronous reset, active-low
- row  in  4  keypad rows, active-low (pulled up externally)
- col  out 4  keypad column drive, one-hot active-low
- tap  out 8  one-cycle press pulses for keys 0-7, bit i = key i
- lft  out 1  one-cycle press pulse for key 8
- rgt  out 1  one-cycle press pulse for key 9
- key_vld  out 1  one-cycle strobe: any key press event this cycle
- key_code out 4  index of the lowest-numbered key pressed this event; held until the next event
- key_dn   out 16 debounced key state, bit k = key k held

Behaviour:
- Clock and reset: one clock, clk. clr is asynchronous, active-low.
- Reset values: col=4'b1110, tap=0, lft=0, rgt=0, key_vld=0, key_code=0, key_dn=0. All counters and synchronizers clear, and the row synchronizer resets to 4'b1111.
- Row synchronizer: row passes through a 2-flop synchronizer before use.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. tick is high in the cycle where count == SCAN_DIV-1.
- Scan (column index c, 0..3):
  - col = ~(1<<c).
  - On tick: sample the synced row for column c, update the debouncers of keys c*4+r (r = 0..3), then advance c to (c+1) mod 4.
  - Each key is therefore sampled once every 4*SCAN_DIV cycles.
- Debounce (per key): saturating counter d in 0..DEB_CNT plus state bit s.
  - Sample pressed (row bit 0): d increments toward DEB_CNT. If d reaches DEB_CNT while s=0, s is set and a press event fires.
  - Sample released: d decrements toward 0. If d reaches 0 while s=1, s clears. Release produces no event.
  - This gives hysteresis; a bouncing input that alternates every sample never fires.
- Event timing: the press event is registered. tap/lft/rgt/key_vld are high in the cycle after the tick edge that sets s, for exactly one cycle.
- Simultaneous events: several rows in the same column can fire on the same tick.
  - All matching tap bits (and lft/rgt) assert together.
  - key_code takes the lowest key index among them.
- Held key: no further events until release and re-press (unless the optional feature is enabled).
- Key mapping: keys 10-15 produce only key_vld/key_code.
- Ghosting: matrix ghosting is not rejected.
- Reset mid-operation: all debounce progress is lost. No event can occur earlier than DEB_CNT samples after clr deasserts.

Optional Feature:
- Macro: WAM_KPD_REPEAT_EN.
- Enabled: while key 8 or key 9 stays held (s=1), a per-key repeat counter counts completed scan rounds. The corresponding lft/rgt pulse (with key_vld/key_code) re-fires every RPT_SCANS rounds after the initial press. The counter clears on release.
- Disabled: no repeat counters; exactly one event per press.

Decomposition:
- Shared package wam_pkg: NUM_KEYS=16, NUM_COLS=4, NUM_ROWS=4, KEY_LFT=8, KEY_RGT=9, and the debounce counter width derived from DEB_CNT.
- One natural sub-module: wam_kpd_deb, a single-key debounce counter plus state bit with a press-event output, instantiated 16 times. It is enabled by tick and its own column match.

Test Plan:
Bench settings: SCAN_DIV=4, DEB_CNT=3, RPT_SCANS=2; one full scan = 16 cycles. The keypad model pulls row[r] low when col[c] is low and key c*4+r is held.
- Hold key 5 (col1, row1) -> after the 3rd col1 sample, tap=8'b00100000 for one cycle, key_vld=1, key_code=5, key_dn[5]=1. No further pulses while held.
- Key 5 pressed on alternate scans only (bounce) -> no tap, key_vld stays 0, key_dn[5] stays 0.
- Hold keys 0 and 1 together -> tap=8'b00000011 in the same single cycle, key_code=0.
- Hold key 8, then release for 3 scans, then press again -> two lft pulses, tap=0 throughout. Key 9 -> rgt pulse only.
- Pull clr low after 2 pressed samples of key 3, release clr, keep holding -> col=4'b1110 during reset. No event until 3 fresh samples, then tap[3] pulses once.
- With WAM_KPD_REPEAT_EN, hold key 9 for 8 scans -> rgt pulses at the initial press and then every 2 scan rounds. Without the macro -> exactly one rgt pulse.
